irq_controller: RTL and testbench

- Interrupt controller sitting directly upstream of the s1c88 core.
- Latches edge-triggered peripheral interrupt sources into pending flags and masks them with enable bits.
- Arbitrates by programmable 2-bit priority and presents request level plus vector to the CPU.
- Supplies the vector byte on the data bus during the CPU's iack read cycle. Its registers are memory-mapped on the CPU bus.

---
 rtl/s1c88_pkg.sv | 29 ++
 rtl/irq_priority_encoder.sv | 26 ++
 rtl/irq_controller.sv | 209 ++++++++++++++++++++
 tb/tb_irq_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/s1c88_pkg.sv
// rtl/s1c88_pkg.sv - shared s1c88 bus command, interrupt vector and ack FSM definitions.
package s1c88_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE      = 2'd0,
    BUS_IRQ_READ  = 2'd1,
    BUS_MEM_WRITE = 2'd2,
    BUS_MEM_READ  = 2'd3
  } bus_command_e;

  localparam logic [7:0] IRQ_VECTOR_SPURIOUS = 8'hFF;

  localparam logic [2:0] REG_ENABLE_LO  = 3'd0;
  localparam logic [2:0] REG_ENABLE_HI  = 3'd1;
  localparam logic [2:0] REG_PENDING_LO = 3'd2;
  localparam logic [2:0] REG_PENDING_HI = 3'd3;
  localparam logic [2:0] REG_PRIO_0     = 3'd4;
  localparam logic [2:0] REG_PRIO_1     = 3'd5;
  localparam logic [2:0] REG_PRIO_2     = 3'd6;
  localparam logic [2:0] REG_PRIO_3     = 3'd7;
  localparam int         REG_COUNT      = 8;

  typedef enum logic [1:0] {
    ACK_IDLE  = 2'd0,
    ACK_LATCH = 2'd1,
    ACK_DRIVE = 2'd2
  } ack_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - picks the highest-priority enabled pending source; ties go to the lowest index.
module irq_priority_encoder (
  input  logic [15:0] pending,
  input  logic [15:0] enable,
  input  logic [31:0] prio,
  output logic        valid,
  output logic [1:0]  level,
  output logic [3:0]  index
);

  // Ascending scan with strict compare keeps the lowest index on ties;
  // starting level at 0 makes priority 0 act as a mask.
  always_comb begin
    valid = 1'b0;
    level = 2'd0;
    index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pending[i] && enable[i] && (prio[2*i +: 2] > level)) begin
        valid = 1'b1;
        level = prio[2*i +: 2];
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - s1c88 interrupt controller: enable/pending/priority registers, arbitration, iack vector.
// Define IRQ_AUTO_CLEAR_EN to clear the acknowledged source's pending flag when iack ends.
module irq_controller
  import s1c88_pkg::*;
#(
  parameter int          NUM_SOURCES = 16,
  parameter logic [23:0] BASE_ADDR   = 24'h002020,
  parameter logic [7:0]  VECTOR_BASE = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic [23:0]            bus_address,
  input  logic [7:0]             bus_data_in,
  input  logic [1:0]             bus_status,
  input  logic                   bus_read,
  input  logic                   bus_write,
  input  logic                   bus_iack,
  output logic [7:0]             bus_data_out,
  output logic                   bus_data_oe,
  output logic                   irq_req,
  output logic [1:0]             irq_level
);

  localparam logic [15:0] SRC_MASK  = 16'((32'd1 << NUM_SOURCES) - 32'd1);
  localparam logic [31:0] PRIO_MASK = 32'((64'd1 << (2 * NUM_SOURCES)) - 64'd1);

  logic [15:0]  src_ext;
  logic [15:0]  prev_q;
  logic [15:0]  enable_q, enable_d;
  logic [15:0]  pending_q, pending_d;
  logic [31:0]  prio_q, prio_d;
  logic [15:0]  w1c;
  logic [15:0]  auto_clr;
  logic [15:0]  edge_set;

  bus_command_e cmd;
  logic [23:0]  offset;
  logic         reg_hit;
  logic [2:0]   reg_off;
  logic [7:0]   rd_data;

  logic         write_q, iack_q;
  logic         write_pulse, iack_rise, iack_fall;
  logic         reg_read_req, vec_drive;

  logic         win_valid;
  logic [1:0]   win_level;
  logic [3:0]   win_index;

  ack_state_e   state_q, state_d;
  logic [3:0]   ack_idx_q;
  logic         ack_spur_q;
  logic [7:0]   ack_vec;

  logic [7:0]   data_out_q;
  logic         oe_q;
  logic         irq_req_q;
  logic [1:0]   irq_level_q;

  always_comb begin
    src_ext                  = '0;
    src_ext[NUM_SOURCES-1:0] = irq_src;
  end

  assign cmd     = bus_command_e'(bus_status);
  // Addresses below BASE_ADDR wrap to a large offset and miss.
  assign offset  = bus_address - BASE_ADDR;
  assign reg_hit = (offset < 24'(REG_COUNT));
  assign reg_off = offset[2:0];

  assign write_pulse  = bus_write && !write_q && (cmd == BUS_MEM_WRITE) && reg_hit;
  assign iack_rise    = bus_iack && !iack_q;
  assign iack_fall    = !bus_iack && iack_q;
  assign reg_read_req = (state_q == ACK_IDLE) && (cmd == BUS_MEM_READ) && bus_read && reg_hit;

  irq_priority_encoder u_prio_enc (
    .pending (pending_q),
    .enable  (enable_q),
    .prio    (prio_q),
    .valid   (win_valid),
    .level   (win_level),
    .index   (win_index)
  );

  always_comb begin
    rd_data = 8'h00;
    case (reg_off)
      REG_ENABLE_LO:  rd_data = enable_q[7:0];
      REG_ENABLE_HI:  rd_data = enable_q[15:8];
      REG_PENDING_LO: rd_data = pending_q[7:0];
      REG_PENDING_HI: rd_data = pending_q[15:8];
      REG_PRIO_0:     rd_data = prio_q[7:0];
      REG_PRIO_1:     rd_data = prio_q[15:8];
      REG_PRIO_2:     rd_data = prio_q[23:16];
      default:        rd_data = prio_q[31:24];
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    prio_d   = prio_q;
    w1c      = '0;
    if (write_pulse) begin
      case (reg_off)
        REG_ENABLE_LO:  enable_d[7:0]   = bus_data_in;
        REG_ENABLE_HI:  enable_d[15:8]  = bus_data_in;
        REG_PENDING_LO: w1c[7:0]        = bus_data_in;
        REG_PENDING_HI: w1c[15:8]       = bus_data_in;
        REG_PRIO_0:     prio_d[7:0]     = bus_data_in;
        REG_PRIO_1:     prio_d[15:8]    = bus_data_in;
        REG_PRIO_2:     prio_d[23:16]   = bus_data_in;
        default:        prio_d[31:24]   = bus_data_in;
      endcase
    end
    enable_d = enable_d & SRC_MASK;
    prio_d   = prio_d & PRIO_MASK;
  end

  always_comb begin
    auto_clr = '0;
`ifdef IRQ_AUTO_CLEAR_EN
    if ((state_q == ACK_DRIVE) && iack_fall && !ack_spur_q)
      auto_clr = 16'd1 << ack_idx_q;
`endif
  end

  // New edges are ORed in last so a same-cycle clear never loses an interrupt.
  assign edge_set  = src_ext & ~prev_q;
  assign pending_d = ((pending_q & ~w1c & ~auto_clr) | edge_set) & SRC_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      enable_q    <= '0;
      pending_q   <= '0;
      prio_q      <= '0;
      write_q     <= 1'b0;
      iack_q      <= 1'b0;
      irq_req_q   <= 1'b0;
      irq_level_q <= 2'd0;
      ack_idx_q   <= 4'd0;
      ack_spur_q  <= 1'b0;
    end else begin
      prev_q      <= src_ext;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      prio_q      <= prio_d;
      write_q     <= bus_write;
      iack_q      <= bus_iack;
      irq_req_q   <= win_valid;
      irq_level_q <= win_level;
      if ((state_q == ACK_IDLE) && iack_rise) begin
        ack_idx_q  <= win_index;
        ack_spur_q <= !win_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACK_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACK_IDLE: begin
        if (iack_rise) state_d = ACK_LATCH;
      end
      ACK_LATCH: begin
        if (iack_fall)
          state_d = ACK_IDLE;
        else if (bus_read && ((cmd == BUS_IRQ_READ) || (cmd == BUS_MEM_READ)))
          state_d = ACK_DRIVE;
      end
      ACK_DRIVE: begin
        if (iack_fall) state_d = ACK_IDLE;
      end
      default: state_d = ACK_IDLE;
    endcase
  end

  assign ack_vec   = ack_spur_q ? IRQ_VECTOR_SPURIOUS : (VECTOR_BASE + {4'h0, ack_idx_q});
  assign vec_drive = (state_d == ACK_DRIVE) && bus_read;

  // The captured vector owns the data bus for the whole acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= 8'hFF;
      oe_q       <= 1'b0;
    end else if (vec_drive) begin
      data_out_q <= ack_vec;
      oe_q       <= 1'b1;
    end else if (reg_read_req) begin
      data_out_q <= rd_data;
      oe_q       <= 1'b1;
    end else begin
      data_out_q <= 8'hFF;
      oe_q       <= 1'b0;
    end
  end

  assign bus_data_out = data_out_q;
  assign bus_data_oe  = oe_q;
  assign irq_req      = irq_req_q;
  assign irq_level    = irq_level_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller register access, arbitration and acknowledge.
module tb_irq_controller;

  localparam logic [23:0] BASE = 24'h002020;
`ifdef IRQ_AUTO_CLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irq_src;
  logic [23:0] bus_address;
  logic [7:0]  bus_data_in;
  logic [1:0]  bus_status;
  logic        bus_read, bus_write, bus_iack;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic        irq_req;
  logic [1:0]  irq_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  irq_controller #(
    .NUM_SOURCES (16),
    .BASE_ADDR   (BASE),
    .VECTOR_BASE (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_src      (irq_src),
    .bus_address  (bus_address),
    .bus_data_in  (bus_data_in),
    .bus_status   (bus_status),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_iack     (bus_iack),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .irq_req      (irq_req),
    .irq_level    (irq_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_compare(input string tag);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, 32'(bus_data_out), 32'(exp_q.pop_front()));
  endtask

  task automatic reg_write(input int off, input logic [7:0] d);
    bus_address = 24'(BASE + 24'(off));
    bus_data_in = d;
    bus_status  = 2'd2;
    bus_write   = 1'b1;
    @(negedge clk);
    bus_write  = 1'b0;
    bus_status = 2'd0;
    @(negedge clk);
  endtask

  task automatic reg_read(input int off, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    bus_address = 24'(BASE + 24'(off));
    bus_status  = 2'd3;
    bus_read    = 1'b1;
    @(negedge clk);
    check({tag, "_oe"}, 32'(bus_data_oe), 32'd1);
    sb_compare(tag);
    bus_read   = 1'b0;
    bus_status = 2'd0;
    @(negedge clk);
    check({tag, "_oe_drop"}, 32'(bus_data_oe), 32'd0);
  endtask

  task automatic pulse(input logic [15:0] mask);
    irq_src = mask;
    @(negedge clk);
    irq_src = 16'h0000;
    @(negedge clk);
  endtask

  task automatic ack_begin(input logic [7:0] exp, input string tag);
    int k;
    exp_q.push_back(exp);
    bus_iack = 1'b1;
    @(negedge clk);
    bus_status = 2'd1;
    bus_read   = 1'b1;
    @(negedge clk);
    k = 0;
    while (!bus_data_oe && k < 4) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_oe"}, 32'(bus_data_oe), 32'd1);
    sb_compare(tag);
  endtask

  task automatic ack_end(input string tag);
    bus_read   = 1'b0;
    bus_status = 2'd0;
    bus_iack   = 1'b0;
    @(negedge clk);
    check({tag, "_oe_end"}, 32'(bus_data_oe), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    irq_src = '0; bus_address = '0; bus_data_in = '0; bus_status = '0;
    bus_read = 1'b0; bus_write = 1'b0; bus_iack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_data", 32'(bus_data_out), 32'hFF);
    check("rst_oe", 32'(bus_data_oe), 32'd0);
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_level", 32'(irq_level), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) reg_read(i, 8'h00, $sformatf("rst_reg%0d", i));
    bus_address = BASE + 24'd8; bus_status = 2'd3; bus_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("off8_oe", 32'(bus_data_oe), 32'd0);
    bus_read = 1'b0; bus_status = 2'd0;
    @(negedge clk);

    reg_write(4, 8'h01);
    reg_write(5, 8'h03);
    reg_write(0, 8'h11);
    pulse(16'h0011);
    check("s04_req", 32'(irq_req), 32'd1);
    check("s04_level", 32'(irq_level), 32'd3);
    ack_begin(8'h04, "s04_vec");
    ack_end("s04");
    reg_read(2, AUTO ? 8'h01 : 8'h11, "s04_pend");
    reg_write(2, 8'h11);
    check("s04_clr_req", 32'(irq_req), 32'd0);

    reg_write(4, 8'h21);
    reg_write(5, 8'h0B);
    reg_write(0, 8'h24);
    pulse(16'h0024);
    check("tie_req", 32'(irq_req), 32'd1);
    check("tie_level", 32'(irq_level), 32'd2);
    ack_begin(8'h02, "tie_vec");
    ack_end("tie");
    reg_write(2, 8'h04);
    check("tie5_req", 32'(irq_req), 32'd1);
    check("tie5_level", 32'(irq_level), 32'd2);
    ack_begin(8'h05, "tie5_vec");
    ack_end("tie5");
    reg_write(2, 8'hFF);

    reg_write(0, 8'h02);
    pulse(16'h0002);
    check("p0_req", 32'(irq_req), 32'd0);
    check("p0_level", 32'(irq_level), 32'd0);
    reg_read(2, 8'h02, "p0_pend");
    reg_write(2, 8'h02);

    reg_write(4, 8'h61);
    reg_write(5, 8'hCB);
    reg_write(0, 8'h88);
    pulse(16'h0008);
    check("s3_level", 32'(irq_level), 32'd1);
    ack_begin(8'h03, "s3_vec");
    pulse(16'h0080);
    check("drv_hold_oe", 32'(bus_data_oe), 32'd1);
    check("drv_hold_vec", 32'(bus_data_out), 32'h03);
    ack_end("s3");
    @(negedge clk);
    check("s7_level", 32'(irq_level), 32'd3);
    reg_read(2, AUTO ? 8'h80 : 8'h88, "auto_pend");

    irq_src = 16'h0008;
    bus_address = BASE + 24'd2; bus_data_in = 8'h08; bus_status = 2'd2; bus_write = 1'b1;
    @(negedge clk);
    irq_src = 16'h0000; bus_write = 1'b0; bus_status = 2'd0;
    @(negedge clk);
    reg_read(2, 8'h88, "set_wins");
    reg_write(2, 8'hFF);
    check("clr_all_req", 32'(irq_req), 32'd0);

    ack_begin(8'hFF, "spur_vec");
    ack_end("spur");

    bus_iack = 1'b1;
    @(negedge clk);
    bus_iack = 1'b0;
    @(negedge clk);
    reg_read(0, 8'h88, "latch_abort");

    pulse(16'h0008);
    ack_begin(8'h03, "rst_drv_vec");
    reset = 1'b1;
    #1;
    check("rst_drv_oe", 32'(bus_data_oe), 32'd0);
    check("rst_drv_data", 32'(bus_data_out), 32'hFF);
    @(negedge clk);
    bus_read = 1'b0; bus_status = 2'd0; bus_iack = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reg_read(0, 8'h00, "rst_drv_en");
    reg_read(2, 8'h00, "rst_drv_pend");
    check("rst_drv_req", 32'(irq_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
